// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoder control and ID operands for EX,
// with load-use stall/bubble, redirect flush, illegal-opcode sanitising and a stall counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode_d,
    input  logic        alusrc_d,
    input  logic        regwrite_d,
    input  logic        memread_d,
    input  logic        memwrite_d,
    input  logic [1:0]  mem2reg_d,
    input  logic [1:0]  branch_d,
    input  logic [1:0]  aluop_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] rs1_data_d,
    input  logic [31:0] rs2_data_d,
    input  logic [31:0] imm_d,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic [2:0]  funct3_d,
    input  logic        funct7b5_d,
    input  logic        flush_i,
    output logic        alusrc_e,
    output logic        regwrite_e,
    output logic        memread_e,
    output logic        memwrite_e,
    output logic [1:0]  mem2reg_e,
    output logic [1:0]  branch_e,
    output logic [1:0]  aluop_e,
    output logic [31:0] pc_e,
    output logic [31:0] rs1_data_e,
    output logic [31:0] rs2_data_e,
    output logic [31:0] imm_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic [2:0]  funct3_e,
    output logic        funct7b5_e,
    output logic        valid_e,
    output logic        illegal_e,
    output logic        stall_o,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] REGALU     = 2'b00;
    localparam logic [1:0] BCN        = 2'b00;
    localparam logic [6:0] OPTIPOR    = 7'b0110011;
    localparam logic [6:0] OPLOAD     = 7'b0000011;
    localparam logic [6:0] OPSTORE    = 7'b0100011;
    localparam logic [6:0] OPBRANCH   = 7'b1100011;
    localparam logic [6:0] OPIMEDIATO = 7'b0010011;
    localparam logic [6:0] OPJALR     = 7'b1100111;
    localparam logic [6:0] OPJAL      = 7'b1101111;

    logic        legal_s;
    logic        uses_rs1_s;
    logic        uses_rs2_s;
    logic        hazard_s;
    logic        load_s;
    logic        illegal_nxt_s;
    logic [15:0] stall_cnt_r;

    // Opcode legality and source-operand usage; only the opcode is inspected.
    always_comb begin
        legal_s    = 1'b0;
        uses_rs2_s = 1'b0;
        case (opcode_d)
            OPTIPOR, OPSTORE, OPBRANCH: begin
                legal_s    = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OPLOAD, OPIMEDIATO, OPJALR, OPJAL: begin
                legal_s    = 1'b1;
                uses_rs2_s = 1'b0;
            end
            default: begin
                legal_s    = 1'b0;
                uses_rs2_s = 1'b0;
            end
        endcase
        uses_rs1_s = legal_s & (opcode_d != OPJAL);
    end

    assign hazard_s = memread_e & valid_e & (rd_e != 5'd0) &
                      ((uses_rs1_s & (rs1_d == rd_e)) | (uses_rs2_s & (rs2_d == rd_e)));

    // A redirect discards the wrong-path ID instruction, so it never needs holding.
    assign stall_o  = hazard_s & ~flush_i & ~reset;

    // Next-slot selection: flush, then hazard, then illegal opcode, else load.
    always_comb begin
        load_s        = 1'b0;
        illegal_nxt_s = 1'b0;
        if (flush_i) begin
            load_s        = 1'b0;
            illegal_nxt_s = 1'b0;
        end else if (hazard_s) begin
            load_s        = 1'b0;
            illegal_nxt_s = 1'b0;
        end else if (!legal_s) begin
            load_s        = 1'b0;
            illegal_nxt_s = 1'b1;
        end else begin
            load_s        = 1'b1;
            illegal_nxt_s = 1'b0;
        end
    end

    // Pipeline register; decoder fields only pass through when the slot is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alusrc_e   <= 1'b0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
            memwrite_e <= 1'b0;
            mem2reg_e  <= REGALU;
            branch_e   <= BCN;
            aluop_e    <= 2'b00;
            pc_e       <= 32'd0;
            rs1_data_e <= 32'd0;
            rs2_data_e <= 32'd0;
            imm_e      <= 32'd0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            funct3_e   <= 3'd0;
            funct7b5_e <= 1'b0;
            valid_e    <= 1'b0;
            illegal_e  <= 1'b0;
        end else begin
            alusrc_e   <= load_s ? alusrc_d   : 1'b0;
            regwrite_e <= load_s ? regwrite_d : 1'b0;
            memread_e  <= load_s ? memread_d  : 1'b0;
            memwrite_e <= load_s ? memwrite_d : 1'b0;
            mem2reg_e  <= load_s ? mem2reg_d  : REGALU;
            branch_e   <= load_s ? branch_d   : BCN;
            aluop_e    <= load_s ? aluop_d    : 2'b00;
            pc_e       <= load_s ? pc_d       : 32'd0;
            rs1_data_e <= load_s ? rs1_data_d : 32'd0;
            rs2_data_e <= load_s ? rs2_data_d : 32'd0;
            imm_e      <= load_s ? imm_d      : 32'd0;
            rs1_e      <= load_s ? rs1_d      : 5'd0;
            rs2_e      <= load_s ? rs2_d      : 5'd0;
            rd_e       <= load_s ? rd_d       : 5'd0;
            funct3_e   <= load_s ? funct3_d   : 3'd0;
            funct7b5_e <= load_s ? funct7b5_d : 1'b0;
            valid_e    <= load_s;
            illegal_e  <= illegal_nxt_s;
        end
    end

    // Saturating stall counter for debug.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_o && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule
